// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential nibble comparator: FSM state type and
// the nibble width of the compare unit.
package cmp_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cmp4bit.sv
// 4-bit unsigned magnitude comparator. Exactly one output is high for any input.
module cmp4bit
  import cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  output logic                o_equal,
  output logic                o_more,
  output logic                o_less
);

  assign o_equal = (i_a == i_b);
  assign o_more  = (i_a >  i_b);
  assign o_less  = (i_a <  i_b);

endmodule

// File: rtl/cmp_nibble_seq.sv
// Sequential wide-operand magnitude comparator. Walks the latched operands one
// nibble per clock, MSB nibble first, through a single cmp4bit and registers a
// one-hot equal/more/less verdict with a start/busy/done handshake.
// Optional feature macro: CMP_EARLY_EXIT_EN -- when defined, the scan stops at
// the first unequal nibble (latency 1..N); otherwise all N nibbles are scanned.
module cmp_nibble_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             more,
  output logic             less
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(N);

  state_t              r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [IDX_W-1:0]    r_idx;
  // Sticky "already decided" flags: set by the first unequal nibble only.
  logic                r_gt;
  logic                r_lt;

  logic [NIBBLE_W-1:0] w_nib_a;
  logic [NIBBLE_W-1:0] w_nib_b;
  logic                w_nib_eq;
  logic                w_nib_gt;
  logic                w_nib_lt;
  logic                w_eq_next;
  logic                w_gt_next;
  logic                w_lt_next;
  logic                w_last;

  assign w_nib_a = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_nib_b = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

  cmp4bit u_cmp4bit (
    .i_a     (w_nib_a),
    .i_b     (w_nib_b),
    .o_equal (w_nib_eq),
    .o_more  (w_nib_gt),
    .o_less  (w_nib_lt)
  );

  // Once a verdict exists it is kept; lower nibbles only matter while all
  // higher nibbles have been equal.
  assign w_gt_next = r_gt | (~r_lt & w_nib_gt);
  assign w_lt_next = r_lt | (~r_gt & w_nib_lt);
  assign w_eq_next = ~r_gt & ~r_lt & w_nib_eq;

`ifdef CMP_EARLY_EXIT_EN
  assign w_last = (r_idx == '0) || !w_nib_eq;
`else
  assign w_last = (r_idx == '0);
`endif

  // Control FSM: accepts a request in IDLE, scans nibbles in RUN, and
  // registers the verdict together with the done pulse.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      equal   <= 1'b0;
      more    <= 1'b0;
      less    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= IDX_W'(N - 1);
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            equal   <= 1'b0;
            more    <= 1'b0;
            less    <= 1'b0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_gt <= w_gt_next;
          r_lt <= w_lt_next;
          if (w_last) begin
            equal   <= w_eq_next;
            more    <= w_gt_next;
            less    <= w_lt_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_nibble_seq.sv
// Self-checking bench for cmp_nibble_seq (WIDTH=16). A reference model keyed on
// the clock pushes expected verdicts and due cycles into a scoreboard queue; a
// monitor on the falling edge pops and compares whenever done is seen.
// Honors CMP_EARLY_EXIT_EN the same way the design does.
module tb_cmp_nibble_seq;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  typedef struct {
    logic [2:0]  res;   // {equal, more, less}
    int unsigned due;   // cycle stamp at which done must be observed
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             equal;
  logic             more;
  logic             less;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned m_rem    = 0;
  bit          m_done   = 0;
  exp_t        sb_q[$];

  cmp_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .equal (equal),
    .more  (more),
    .less  (less)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Latency from the spec's rules: position of first differing nibble from the
  // MSB when early exit is enabled, otherwise always N.
  function automatic int unsigned ref_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = 0; i < N; i++) begin
      if (((x >> (4 * (N - 1 - i))) & 16'hF) != ((y >> (4 * (N - 1 - i))) & 16'hF))
        return i + 1;
    end
`endif
    return N;
  endfunction

  function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  // Reference model: tracks how many cycles the current compare still needs.
  always @(posedge clk) begin
    exp_t e;
    int unsigned k;
    cyc++;
    m_done = 0;
    if (!rst_n) begin
      m_rem = 0;
      sb_q.delete();
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else if (start) begin
      k     = ref_k(a, b);
      e.res = ref_res(a, b);
      e.due = cyc + k;
      sb_q.push_back(e);
      m_rem = k;
    end
  end

  // Monitor: handshake every cycle, verdict and latency whenever done is seen.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
      check("done", {31'd0, done}, {31'd0, m_done});
      if (done) begin
        if (sb_q.size() == 0) begin
          check("done_without_request", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("result_eq_more_less", {29'd0, equal, more, less}, {29'd0, e.res});
          check("done_cycle", cyc, e.due);
        end
      end else if (busy) begin
        check("result_cleared_while_busy", {29'd0, equal, more, less}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int unsigned t = 0;
    while (m_rem != 0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (m_rem != 0) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Pulse start for one cycle with the given operands, then wait for the end.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    wait_idle();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {27'd0, busy, done, equal, more, less}, 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] x, y;
    int unsigned nib;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("after_release_idle");

    issue(16'h1234, 16'h1234);
    issue(16'h9000, 16'h1FFF);
    issue(16'h12F0, 16'h12F1);
    check("hold_after_done", {29'd0, equal, more, less}, 32'b001);
    @(negedge clk);
    check("hold_two_after_done", {29'd0, equal, more, less}, 32'b001);

    // Back-to-back: start held high through busy and into the done cycle.
    start = 1'b1;
    a     = 16'h0001;
    b     = 16'h0002;
    @(negedge clk);
    a     = 16'hFFFF;
    b     = 16'h0000;
    wait_idle();
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    // Asynchronous reset in the middle of a full-length compare.
    start = 1'b1;
    a     = 16'h5555;
    b     = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_run");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_all_zero("no_done_after_reset");

    // Random compares; b often shares a prefix with a to spread latencies.
    for (int i = 0; i < 60; i++) begin
      x = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = WIDTH'($urandom);
        default: begin
          nib = $urandom_range(0, N - 1);
          y   = x;
          y[nib*4 +: 4] = 4'($urandom);
        end
      endcase
      issue(x, y);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
